uart_tx_unit: RTL and testbench

- UART transmitter: serializes one byte per request into an 8N1 frame. Frame = 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Bit timing is derived from the system clock by an integer divider.
- Sits between a byte-producing client (tx_en/tx_din handshake) and the TX pad; tx_busy provides back-pressure.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_unit_if.sv | 10 +
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_tx_unit.sv | 103 ++++++++++
 tb/tb_uart_tx_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DEF_CLK_FREQ = 50000000;
  localparam int unsigned DEF_UART_BPS = 115200;

  // Clock cycles per serial bit (truncating divide; caller guarantees >= 2).
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned bps);
    return clk_freq / bps;
  endfunction

  // Width of a counter that spans 0..div-1.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_tx_unit_if.sv
// Client-side byte handshake and serial line of the UART transmitter.
interface uart_tx_unit_if;
  logic       tx_en;
  logic [7:0] tx_din;
  logic       tx_dout;
  logic       tx_busy;

  modport master (output tx_en, output tx_din, input tx_dout, input tx_busy);
  modport slave  (input tx_en, input tx_din, output tx_dout, output tx_busy);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: cleared while idle, pulses bit_done_o on the last cycle of each bit.
module uart_baud_gen #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic bit_done_o
);
  import uart_pkg::*;

  localparam int unsigned CNT_W = cnt_width(BAUD_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next count and a pulse registered one cycle early so it coincides with cnt==BAUD_DIV-1.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    done_d = 1'b0;
    if (clr_i || (cnt_q == CNT_W'(BAUD_DIV - 1))) begin
      cnt_d = '0;
    end
    if (!clr_i && (cnt_q == CNT_W'(BAUD_DIV - 2))) begin
      done_d = 1'b1;
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bit_done_o = done_q;

endmodule

// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter: one byte per accepted request, busy for the whole frame.
module uart_tx_unit #(
  parameter int unsigned CLK_FREQ = uart_pkg::DEF_CLK_FREQ,
  parameter int unsigned UART_BPS = uart_pkg::DEF_UART_BPS
) (
  input logic            sys_clk,
  input logic            sys_rst,
  uart_tx_unit_if.slave  tx_if
);
  import uart_pkg::*;

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, UART_BPS);

  uart_state_e state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        dout_q, dout_d;
  logic        busy_q, busy_d;
  logic        baud_clr_c;
  logic        bit_done;

  // Bit timing restarts from zero on every frame because the counter is held clear while idle.
  assign baud_clr_c = (state_q == IDLE);

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .clr_i      (baud_clr_c),
    .bit_done_o (bit_done)
  );

  // Next-state and line/busy logic; the shift register feeds bits out LSB first.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    dout_d    = dout_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        dout_d    = 1'b1;
        busy_d    = 1'b0;
        bit_idx_d = '0;
        if (tx_if.tx_en) begin
          shreg_d = tx_if.tx_din;
          dout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          dout_d    = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            dout_d  = 1'b1;
            state_d = STOP;
          end else begin
            dout_d    = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame and idles the line.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      dout_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_if.tx_dout = dout_q;
  assign tx_if.tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit: default-rate and scaled-rate instances against a frame-level model.
module tb_uart_tx_unit;
  import uart_pkg::*;

  localparam int unsigned BIG_DIV = baud_div(DEF_CLK_FREQ, DEF_UART_BPS);
  localparam int unsigned SML_DIV = baud_div(40, 10);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_on  = 1'b0;

  always #5 clk = ~clk;

  uart_tx_unit_if bus_big();
  uart_tx_unit_if bus_sml();

  uart_tx_unit dut_big (
    .sys_clk (clk),
    .sys_rst (rst),
    .tx_if   (bus_big)
  );

  uart_tx_unit #(
    .CLK_FREQ (40),
    .UART_BPS (10)
  ) dut_sml (
    .sys_clk (clk),
    .sys_rst (rst),
    .tx_if   (bus_sml)
  );

  logic       en_a   [2];
  logic [7:0] din_a  [2];
  logic       dout_a [2];
  logic       busy_a [2];
  assign en_a[0]   = bus_big.tx_en;
  assign en_a[1]   = bus_sml.tx_en;
  assign din_a[0]  = bus_big.tx_din;
  assign din_a[1]  = bus_sml.tx_din;
  assign dout_a[0] = bus_big.tx_dout;
  assign dout_a[1] = bus_sml.tx_dout;
  assign busy_a[0] = bus_big.tx_busy;
  assign busy_a[1] = bus_sml.tx_busy;

  function automatic int div_of(input int d);
    return (d == 0) ? int'(BIG_DIV) : int'(SML_DIV);
  endfunction

  // Frame model: a frame is 10*div cycles after acceptance; cycle k is bit k/div of start,data,stop.
  logic       m_busy [2] = '{1'b0, 1'b0};
  int         m_k    [2] = '{0, 0};
  logic [7:0] m_byte [2] = '{8'h00, 8'h00};

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] <= 1'b0;
        m_k[d]    <= 0;
      end else if (!m_busy[d]) begin
        if (en_a[d]) begin
          m_busy[d] <= 1'b1;
          m_k[d]    <= 0;
          m_byte[d] <= din_a[d];
        end
      end else if (m_k[d] == 10 * div_of(d) - 1) begin
        m_busy[d] <= 1'b0;
      end else begin
        m_k[d] <= m_k[d] + 1;
      end
    end
  end

  function automatic logic exp_line(input int d);
    int         bitn;
    logic [7:0] b;
    if (!m_busy[d]) return 1'b1;
    bitn = m_k[d] / div_of(d);
    b    = m_byte[d];
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return b[3'(bitn - 1)];
    return 1'b1;
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (dout_a[d] !== exp_line(d) || busy_a[d] !== m_busy[d]) begin
          n_fail++;
          $display("FAIL model[%0d] t=%0t: dout=%b busy=%b want dout=%b busy=%b",
                   d, $time, dout_a[d], busy_a[d], exp_line(d), m_busy[d]);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic drive(input int d, input logic en, input logic [7:0] din);
    if (d == 0) begin
      bus_big.tx_en  = en;
      bus_big.tx_din = din;
    end else begin
      bus_sml.tx_en  = en;
      bus_sml.tx_din = din;
    end
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (busy_a[d] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (busy_a[d]) check("wait_idle_timeout", 1, 0);
  endtask

  // One frame with hand-written line pattern; tx_din changes right after acceptance.
  task automatic run_literal(input int d, input logic [7:0] data, input logic [7:0] din_after,
                             input logic [9:0] pat, input string name);
    int div = div_of(d);
    int busy_cnt = 0;
    wait_idle(d);
    @(negedge clk);
    drive(d, 1'b1, data);
    for (int cyc = 0; cyc < 10 * div + 3; cyc++) begin
      @(negedge clk);
      if (cyc == 0) drive(d, 1'b0, din_after);
      if (busy_a[d]) busy_cnt++;
      if ((cyc % div) == (div / 2) && (cyc / div) < 10)
        check($sformatf("%s_bit%0d", name, cyc / div), int'(dout_a[d]), int'(pat[cyc / div]));
    end
    check({name, "_busy_len"}, busy_cnt, 10 * div);
  endtask

  initial begin
    int rises [$];
    int lows;
    logic prev;
    drive(0, 1'b1, 8'h2B);
    drive(1, 1'b1, 8'h01);
    #1 rst = 1'b1;
    #1 chk_on = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_dout_big", int'(dout_a[0]), 1);
    check("rst_busy_sml", int'(busy_a[1]), 0);
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);

    run_literal(0, 8'h2B, 8'h2B, 10'b1001010110, "single_2B");
    run_literal(0, 8'hA5, 8'h00, 10'b1101001010, "stable_A5");
    run_literal(1, 8'h01, 8'hFF, 10'b1000000010, "scaled_01");

    // Continuous request: frame period and single idle cycle between frames.
    wait_idle(0);
    @(negedge clk);
    drive(0, 1'b1, 8'h2B);
    prev = busy_a[0];
    lows = 0;
    for (int cyc = 0; cyc < 3 * 4341 + 10; cyc++) begin
      @(negedge clk);
      if (busy_a[0] && !prev) rises.push_back(cyc);
      if (!busy_a[0] && rises.size() == 1) lows++;
      prev = busy_a[0];
    end
    drive(0, 1'b0, 8'h00);
    check("cont_frames", rises.size(), 4);
    if (rises.size() >= 3) begin
      check("cont_period1", rises[1] - rises[0], 4341);
      check("cont_period2", rises[2] - rises[1], 4341);
    end
    check("cont_gap", lows, 1);
    wait_idle(0);

    // Request while busy must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 8'h3C);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    repeat (1000) @(negedge clk);
    drive(0, 1'b1, 8'hFF);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    rises.delete();
    prev = busy_a[0];
    for (int cyc = 0; cyc < 3400 + 60; cyc++) begin
      @(negedge clk);
      if (busy_a[0] && !prev) rises.push_back(cyc);
      prev = busy_a[0];
    end
    check("busy_req_frames", rises.size(), 0);
    check("busy_req_dout", int'(dout_a[0]), 1);
    check("busy_req_busy", int'(busy_a[0]), 0);

    // Randomized traffic on the scaled instance.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      drive(1, ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    // Mid-frame asynchronous reset, released with a request pending.
    drive(1, 1'b1, 8'h55);
    wait_idle(1);
    repeat (15) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_dout", int'(dout_a[1]), 1);
    check("midrst_busy", int'(busy_a[1]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_busy", int'(busy_a[1]), 1);
    check("rel_dout", int'(dout_a[1]), 0);
    drive(1, 1'b0, 8'h00);
    wait_idle(1);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
